dccm_ctrl: RTL and testbench

Request controller in front of the data closely coupled memory. It arbitrates between two requesters (port 0: LSU, port 1: DMA/debug) and serialises their accesses onto the DCCM's word-wide read and write ports. Loads return LSB-aligned, zero-extended data. Sub-word stores are performed as read-modify-write, because the DCCM has no byte enables. Sits between the LSU/DMA and the `dccm` instance.

---
 rtl/mem_pkg.sv | 12 +
 rtl/dccm_lane_merge.sv | 34 +++
 rtl/dccm_ctrl.sv | 153 +++++++++++++++
 tb/tb_dccm_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Memory-access types shared by the LSU, DMA and DCCM request path.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    localparam int DCCM_WORD_W = 32;

endpackage

// File: rtl/dccm_lane_merge.sv
// Byte/half lane handling for the DCCM: inserts store data into a word and
// extracts LSB-aligned, zero-extended load data from it.
module dccm_lane_merge
    import mem_pkg::*;
(
    input  logic [DCCM_WORD_W-1:0] word,
    input  logic [1:0]             addr,
    input  logic [1:0]             size,
    input  logic [DCCM_WORD_W-1:0] wdata,
    output logic [DCCM_WORD_W-1:0] merged,
    output logic [DCCM_WORD_W-1:0] rdata
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        merged = word;
        rdata  = '0;
        case (size)
            MEM_BYTE: begin
                merged[{addr, 3'b000} +: 8] = wdata[7:0];
                rdata[7:0]                  = word[{addr, 3'b000} +: 8];
            end
            MEM_HALF: begin
                merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
                rdata[15:0]                      = word[{addr[1], 4'b0000} +: 16];
            end
            default: begin
                merged = wdata;
                rdata  = word;
            end
        endcase
    end

endmodule

// File: rtl/dccm_ctrl.sv
// Two-port round-robin request controller for the DCCM; serialises loads,
// word stores and read-modify-write sub-word stores onto the word-wide array.
module dccm_ctrl
    import mem_pkg::*;
#(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH * 4),
    localparam int WIDX_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  logic [1:0]                  req_we,
    input  logic [1:0][1:0]             req_size,
    input  logic [1:0][ADDR_W-1:0]      req_addr,
    input  logic [1:0][DCCM_WORD_W-1:0] req_wdata,
    output logic [1:0]                  rsp_valid,
    output logic [DCCM_WORD_W-1:0]      rsp_rdata,
    output logic                        rsp_err,
    output logic [WIDX_W-1:0]           dccm_raddr,
    output logic                        dccm_rvalid_in,
    input  logic [DCCM_WORD_W-1:0]      dccm_rdata,
    input  logic                        dccm_rvalid_out,
    output logic [WIDX_W-1:0]           dccm_waddr,
    output logic                        dccm_wen,
    output logic [DCCM_WORD_W-1:0]      dccm_wdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        ERR
    } state_e;

    state_e                 state;
    logic                   last_grant;
    logic                   id_q;
    logic                   we_q;
    logic [1:0]             size_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DCCM_WORD_W-1:0] wdata_q;

    logic                   gnt;
    logic                   handshake;
    logic                   misaligned;
    logic                   is_word;
    logic [DCCM_WORD_W-1:0] merged;
    logic [DCCM_WORD_W-1:0] load_data;

    // On a tie the port that did not win last time is granted.
    assign gnt       = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign req_ready = (state == IDLE && rst_n && (|req_valid)) ?
                       (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign handshake = |(req_valid & req_ready);

    assign is_word    = (req_size[gnt] != MEM_BYTE) && (req_size[gnt] != MEM_HALF);
    assign misaligned = ((req_size[gnt] == MEM_HALF) && req_addr[gnt][0]) ||
                        (is_word && (req_addr[gnt][1:0] != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= MEM_BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (handshake) begin
                        last_grant <= gnt;
                        id_q       <= gnt;
                        we_q       <= req_we[gnt];
                        size_q     <= req_size[gnt];
                        addr_q     <= req_addr[gnt];
                        wdata_q    <= req_wdata[gnt];
                        if (misaligned)
                            state <= ERR;
                        else if (req_we[gnt] && is_word)
                            state <= WR;
                        else
                            state <= RD_ISSUE;
                    end
                end
                WR:       state <= IDLE;
                RD_ISSUE: state <= RD_WAIT;
                RD_WAIT:  state <= IDLE;
                ERR:      state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    // In WR the latched size is a word, so the merge passes wdata straight through.
    dccm_lane_merge u_lane_merge (
        .word   (dccm_rdata),
        .addr   (addr_q[1:0]),
        .size   (size_q),
        .wdata  (wdata_q),
        .merged (merged),
        .rdata  (load_data)
    );

    always_comb begin
        rsp_valid      = 2'b00;
        rsp_rdata      = '0;
        rsp_err        = 1'b0;
        dccm_raddr     = '0;
        dccm_rvalid_in = 1'b0;
        dccm_waddr     = '0;
        dccm_wen       = 1'b0;
        dccm_wdata     = '0;
        case (state)
            WR: begin
                dccm_wen   = 1'b1;
                dccm_waddr = addr_q[ADDR_W-1:2];
                dccm_wdata = merged;
                rsp_valid  = id_q ? 2'b10 : 2'b01;
            end
            RD_ISSUE: begin
                dccm_rvalid_in = 1'b1;
                dccm_raddr     = addr_q[ADDR_W-1:2];
            end
            RD_WAIT: begin
                rsp_valid = id_q ? 2'b10 : 2'b01;
                if (we_q) begin
                    dccm_wen   = 1'b1;
                    dccm_waddr = addr_q[ADDR_W-1:2];
                    dccm_wdata = merged;
                end else begin
                    rsp_rdata = load_data;
                end
            end
            ERR: begin
                rsp_valid = id_q ? 2'b10 : 2'b01;
                rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    // Read data is consumed unconditionally in RD_WAIT; the DCCM must have it ready.
    a_rdata_valid: assert property (@(posedge clk) disable iff (!rst_n)
        (state == RD_WAIT) |-> dccm_rvalid_out);

endmodule

// File: tb/tb_dccm_ctrl.sv
// Directed bench for dccm_ctrl: vector table of single transactions against a
// DCCM model, plus arbitration and mid-operation reset sequences.
module tb_dccm_ctrl;
    import mem_pkg::*;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 12;
    localparam int WIDX_W = 10;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][1:0]   req_size;
    logic [1:0][11:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [9:0]        dccm_raddr;
    logic              dccm_rvalid_in;
    logic [31:0]       dccm_rdata;
    logic              dccm_rvalid_out;
    logic [9:0]        dccm_waddr;
    logic              dccm_wen;
    logic [31:0]       dccm_wdata;

    logic [31:0] mem [0:DEPTH-1];

    int n_checks = 0;
    int n_pass   = 0;

    dccm_ctrl #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .dccm_raddr      (dccm_raddr),
        .dccm_rvalid_in  (dccm_rvalid_in),
        .dccm_rdata      (dccm_rdata),
        .dccm_rvalid_out (dccm_rvalid_out),
        .dccm_waddr      (dccm_waddr),
        .dccm_wen        (dccm_wen),
        .dccm_wdata      (dccm_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DCCM model: registered read data one cycle after the strobe.
    always @(posedge clk) begin
        if (dccm_wen) mem[dccm_waddr] <= dccm_wdata;
        if (dccm_rvalid_in) dccm_rdata <= mem[dccm_raddr];
        dccm_rvalid_out <= dccm_rvalid_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [1:0]  size;
        logic [11:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        logic        wen;
        logic [9:0]  waddr;
        logic [31:0] wd;
        logic        rd;
    } vec_t;

    vec_t vecs [13];

    task automatic issue(input int p, input logic we, input logic [1:0] size,
                         input logic [11:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output logic wen_seen, output logic [9:0] waddr_seen,
                         output logic [31:0] wdata_seen, output logic rd_seen);
        bit got;
        lat = -1; rdata = '0; err = 1'b0; wen_seen = 1'b0;
        waddr_seen = '0; wdata_seen = '0; rd_seen = 1'b0;
        @(posedge clk); #1;
        req_we[p]    = we;
        req_size[p]  = size;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_valid[p] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (req_ready[p]) got = 1'b1;
        end
        if (!got) begin
            check("ready_timeout", 32'd0, 32'd1);
            req_valid[p] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (dccm_wen) begin
                wen_seen   = 1'b1;
                waddr_seen = dccm_waddr;
                wdata_seen = dccm_wdata;
            end
            if (dccm_rvalid_in) rd_seen = 1'b1;
            if (rsp_valid[p]) begin
                lat   = c;
                rdata = rsp_rdata;
                err   = rsp_err;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rdata, wd_s;
        logic        err, wen_s, rd_s;
        logic [9:0]  wa_s;
        logic [1:0]  grants [4];
        int          ngr, viol;
        bit          spurious;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hA5A5A5A5;
        dccm_rdata      = '0;
        dccm_rvalid_out = 1'b0;
        req_valid = 2'b11;
        req_we    = '0;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        rst_n     = 1'b0;

        // port, we, size, addr, wdata, lat, err, rdata, wen, waddr, wdata, rd
        vecs[0]  = '{0, 1'b0, MEM_WORD, 12'h000, 32'h0,        2, 1'b0, 32'h11223344, 1'b0, 10'd0, 32'h0,        1'b1};
        vecs[1]  = '{0, 1'b1, MEM_BYTE, 12'h001, 32'h000000AB, 2, 1'b0, 32'h0,        1'b1, 10'd0, 32'h1122AB44, 1'b1};
        vecs[2]  = '{0, 1'b0, MEM_BYTE, 12'h002, 32'h0,        2, 1'b0, 32'h00000022, 1'b0, 10'd0, 32'h0,        1'b1};
        vecs[3]  = '{1, 1'b1, MEM_WORD, 12'h008, 32'hDEADBEEF, 1, 1'b0, 32'h0,        1'b1, 10'd2, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{1, 1'b0, MEM_HALF, 12'h00A, 32'h0,        2, 1'b0, 32'h0000DEAD, 1'b0, 10'd0, 32'h0,        1'b1};
        vecs[5]  = '{0, 1'b1, MEM_HALF, 12'h003, 32'h00001234, 1, 1'b1, 32'h0,        1'b0, 10'd0, 32'h0,        1'b0};
        vecs[6]  = '{0, 1'b0, MEM_WORD, 12'h000, 32'h0,        2, 1'b0, 32'h1122AB44, 1'b0, 10'd0, 32'h0,        1'b1};
        vecs[7]  = '{1, 1'b1, MEM_HALF, 12'h006, 32'hFFFF5566, 2, 1'b0, 32'h0,        1'b1, 10'd1, 32'h5566A5A5, 1'b1};
        vecs[8]  = '{0, 1'b0, MEM_WORD, 12'h002, 32'h0,        1, 1'b1, 32'h0,        1'b0, 10'd0, 32'h0,        1'b0};
        vecs[9]  = '{1, 1'b0, MEM_BYTE, 12'h007, 32'h0,        2, 1'b0, 32'h00000055, 1'b0, 10'd0, 32'h0,        1'b1};
        vecs[10] = '{0, 1'b0, MEM_HALF, 12'h004, 32'h0,        2, 1'b0, 32'h0000A5A5, 1'b0, 10'd0, 32'h0,        1'b1};
        vecs[11] = '{1, 1'b1, MEM_BYTE, 12'h000, 32'h00000312, 2, 1'b0, 32'h0,        1'b1, 10'd0, 32'h1122AB12, 1'b1};
        vecs[12] = '{0, 1'b0, MEM_WORD, 12'h004, 32'h0,        2, 1'b0, 32'h5566A5A5, 1'b0, 10'd0, 32'h0,        1'b1};

        #12;
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_outs", {dccm_raddr, dccm_waddr, 9'd0, dccm_wen, dccm_rvalid_in, rsp_err}, 32'd0);
        check("rst_wdata", dccm_wdata, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].port, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                  lat, rdata, err, wen_s, wa_s, wd_s, rd_s);
            check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            check($sformatf("v%0d_wen", i), {31'd0, wen_s}, {31'd0, vecs[i].wen});
            check($sformatf("v%0d_rd", i), {31'd0, rd_s}, {31'd0, vecs[i].rd});
            if (vecs[i].wen) begin
                check($sformatf("v%0d_waddr", i), {22'd0, wa_s}, {22'd0, vecs[i].waddr});
                check($sformatf("v%0d_wdata", i), wd_s, vecs[i].wd);
            end
        end

        // Reset while an RMW byte store sits in RD_WAIT: dropped, no write.
        @(posedge clk); #1;
        req_we[0] = 1'b1; req_size[0] = MEM_BYTE; req_addr[0] = 12'h004;
        req_wdata[0] = 32'h77; req_valid[0] = 1'b1;
        @(negedge clk);
        check("rmw_ready", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("rmw_issue", {31'd0, dccm_rvalid_in}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rstmid_wen", {31'd0, dccm_wen}, 32'd0);
        check("rstmid_outs", {dccm_raddr, dccm_waddr, 10'd0, dccm_rvalid_in, rsp_err}, 32'd0);
        check("rstmid_data", dccm_wdata | rsp_rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || dccm_wen) spurious = 1'b1;
        end
        check("rstmid_no_rsp", {31'd0, spurious}, 32'd0);
        check("rstmid_mem", mem[1], 32'h5566A5A5);

        // Both ports held valid: port 0 first, then strict alternation.
        @(posedge clk); #1;
        req_we    = 2'b00;
        req_size  = {MEM_WORD, MEM_WORD};
        req_addr  = {12'h008, 12'h000};
        req_valid = 2'b11;
        ngr = 0; viol = 0;
        for (int c = 0; c < 40 && ngr < 4; c++) begin
            @(negedge clk);
            if ($countones(req_ready) > 1) viol++;
            if (req_ready != 2'b00) begin
                grants[ngr] = req_ready;
                ngr++;
            end
        end
        req_valid = 2'b00;
        check("arb_count", ngr, 4);
        check("arb_onehot", viol, 0);
        for (int k = 0; k < ngr; k++)
            check($sformatf("arb_grant%0d", k), {30'd0, grants[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
